// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - lock-sequenced clock-enable generator with NUM_CH
// runtime-programmable divider channels producing enable pulses and square waves.
module clock_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DIV_RESET   = 25,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                      clk_in1,
  input  logic                      reset_n,
  input  logic                      src_locked,
  input  logic                      div_wr,
  input  logic [$clog2(NUM_CH)-1:0] div_ch,
  input  logic [CNT_W-1:0]          div_val,
  input  logic [NUM_CH-1:0]         ch_run,
  output logic [NUM_CH-1:0]         ce_out,
  output logic [NUM_CH-1:0]         clk_sq,
  output logic                      locked,
  output logic                      lock_lost
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WAIT_SRC,
    ST_STABLE,
    ST_LOCKED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LOCK_W-1:0] stab_cnt;
  logic [LOCK_W-1:0] stab_cnt_nxt;
  logic              sync1;
  logic              sl;
  logic              lock_ok;

  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sl    <= 1'b0;
    end else begin
      sync1 <= src_locked;
      sl    <= sync1;
    end
  end

  // The sl-high cycle that leaves WAIT_SRC already counts towards LOCK_CYCLES.
  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = stab_cnt;
    case (state)
      ST_WAIT_SRC: begin
        stab_cnt_nxt = '0;
        if (sl) begin
          state_nxt    = ST_STABLE;
          stab_cnt_nxt = LOCK_W'(1);
        end
      end
      ST_STABLE: begin
        if (!sl) begin
          state_nxt    = ST_WAIT_SRC;
          stab_cnt_nxt = '0;
        end else if (stab_cnt >= LOCK_W'(LOCK_CYCLES - 1)) begin
          state_nxt    = ST_LOCKED;
          stab_cnt_nxt = '0;
        end else begin
          stab_cnt_nxt = stab_cnt + LOCK_W'(1);
        end
      end
      ST_LOCKED: begin
        stab_cnt_nxt = '0;
        if (!sl) begin
          state_nxt = ST_WAIT_SRC;
        end
      end
      default: begin
        state_nxt    = ST_WAIT_SRC;
        stab_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_WAIT_SRC;
      stab_cnt  <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      stab_cnt  <= stab_cnt_nxt;
      locked    <= lock_ok;
      lock_lost <= lock_lost | ((state == ST_LOCKED) & ~sl);
    end
  end

  // Channels follow the next lock state so their outputs rise and fall on the same edge as locked.
  assign lock_ok = (state_nxt == ST_LOCKED);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n_eff;
    logic             sel;
    logic             active;
    logic             terminal;
    logic             ce_r;
    logic             sq_r;

    assign sel      = div_wr && (32'(div_ch) < NUM_CH) && (32'(div_ch) == i);
    assign n_eff    = (ratio == '0) ? CNT_W'(1) : ratio;
    assign active   = lock_ok & ch_run[i];
    assign terminal = active && (count == n_eff - CNT_W'(1));

    always_ff @(posedge clk_in1 or negedge reset_n) begin
      if (!reset_n) begin
        ratio  <= CNT_W'(DIV_RESET);
        shadow <= CNT_W'(DIV_RESET);
        count  <= '0;
        ce_r   <= 1'b0;
        sq_r   <= 1'b0;
      end else begin
        if (sel) begin
          shadow <= div_val;
        end
        // A write coinciding with the terminal count governs the very next period.
        if (!active || terminal) begin
          ratio <= sel ? div_val : shadow;
        end
        if (!active) begin
          count <= '0;
          ce_r  <= 1'b0;
          sq_r  <= 1'b0;
        end else if (terminal) begin
          count <= '0;
          ce_r  <= 1'b1;
          sq_r  <= ~sq_r;
        end else begin
          count <= count + CNT_W'(1);
          ce_r  <= 1'b0;
        end
      end
    end

    assign ce_out[i] = ce_r;
    assign clk_sq[i] = sq_r;
  end

endmodule
